// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache victim write-back buffer.
// The package widths size the victim entry storage; the top-level parameters default to them.
package cache_pkg;

    localparam int CACHE_NUMWAYS = 4;
    localparam int CACHE_LINELEN = 512;
    localparam int CACHE_BEATW   = 64;
    localparam int CACHE_ADRW    = 56;
    localparam int CACHE_DEPTH   = 2;
    localparam int BEATS         = CACHE_LINELEN / CACHE_BEATW;

    typedef enum logic {
        IDLE,
        BURST
    } drain_state_t;

    typedef struct packed {
        logic                     valid;
        logic [CACHE_ADRW-1:0]    adr;
        logic [CACHE_LINELEN-1:0] line;
    } victim_entry_t;

    // A single-beat line still needs a one-bit beat counter.
    function automatic int cntWidth(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// One-hot AND-OR selector picking a way's line and dirty bit; shared with the cache data path.
module cache_victim_sel #(
    parameter int NUMWAYS = 4,
    parameter int LINELEN = 512
) (
    input  logic [NUMWAYS-1:0]         victimWay,
    input  logic [NUMWAYS-1:0]         dirtyWay,
    input  logic [NUMWAYS*LINELEN-1:0] lineDataWay,
    output logic [LINELEN-1:0]         selLine,
    output logic                       selDirty
);

    // With a one-hot select the OR of masked ways is exactly the chosen way.
    always_comb begin
        selLine  = '0;
        selDirty = 1'b0;
        for (int i = 0; i < NUMWAYS; i++) begin
            selLine  = selLine | (lineDataWay[i*LINELEN +: LINELEN] & {LINELEN{victimWay[i]}});
            selDirty = selDirty | (dirtyWay[i] & victimWay[i]);
        end
    end

endmodule

// File: rtl/cache_victim_wbuf.sv
// Victim write-back buffer: queues dirty evicted lines and drains them to the bus as beat bursts.
// Define CACHE_VICTIM_WBUF_FORWARD_EN to return pending line data on a probe hit.
module cache_victim_wbuf
    import cache_pkg::*;
#(
    parameter int NUMWAYS = CACHE_NUMWAYS,
    parameter int LINELEN = CACHE_LINELEN,
    parameter int BEATW   = CACHE_BEATW,
    parameter int ADRW    = CACHE_ADRW,
    parameter int DEPTH   = CACHE_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       EvictReq,
    output logic                       EvictReady,
    input  logic [NUMWAYS-1:0]         VictimWay,
    input  logic [NUMWAYS-1:0]         DirtyWay,
    input  logic [NUMWAYS*LINELEN-1:0] LineDataWay,
    input  logic [ADRW-1:0]            VictimAdr,
    output logic                       BusValid,
    output logic [ADRW-1:0]            BusAdr,
    output logic [BEATW-1:0]           BusData,
    output logic                       BusLast,
    input  logic                       BusReady,
    input  logic [ADRW-1:0]            ProbeAdr,
    output logic                       ProbeHit,
    output logic [LINELEN-1:0]         ProbeData,
    output logic                       Empty
);

    localparam int NBEATS = LINELEN / BEATW;
    localparam int CNTW   = cntWidth(NBEATS);
    localparam int PTRW   = $clog2(DEPTH);

    victim_entry_t      entries [DEPTH];
    logic [PTRW-1:0]    wrPtr;
    logic [PTRW-1:0]    rdPtr;
    logic [CNTW-1:0]    beatCnt;
    drain_state_t       state;
    drain_state_t       stateNext;

    logic [LINELEN-1:0] selLine;
    logic               selDirty;
    logic [DEPTH-1:0]   validVec;
    logic               full;
    logic               empty;
    logic               capture;
    logic               beatAccept;
    logic               lastBeat;

    cache_victim_sel #(
        .NUMWAYS(NUMWAYS),
        .LINELEN(LINELEN)
    ) u_sel (
        .victimWay  (VictimWay),
        .dirtyWay   (DirtyWay),
        .lineDataWay(LineDataWay),
        .selLine    (selLine),
        .selDirty   (selDirty)
    );

    // Occupancy comes straight from the registered valid bits, so there is no drain-to-capture bypass.
    always_comb begin
        validVec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            validVec[i] = entries[i].valid;
        end
    end

    assign full       = &validVec;
    assign empty      = ~|validVec;
    assign EvictReady = ~full;
    assign Empty      = empty;
    assign capture    = EvictReq & ~full & selDirty;
    assign lastBeat   = (beatCnt == CNTW'(NBEATS - 1));
    assign beatAccept = BusValid & BusReady;

    // Capture writes at wrPtr and drain retires at rdPtr; they never collide because capture needs a free slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (capture) begin
                entries[wrPtr] <= '{valid: 1'b1, adr: VictimAdr, line: selLine};
                wrPtr          <= wrPtr + 1'b1;
            end
            if (beatAccept && lastBeat) begin
                entries[rdPtr].valid <= 1'b0;
                rdPtr                <= rdPtr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            beatCnt <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE) begin
                beatCnt <= '0;
            end else if (beatAccept) begin
                beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
            end
        end
    end

    // Returning to IDLE after the last beat gives the mandatory idle cycle between bursts.
    always_comb begin
        stateNext = state;
        BusValid  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    stateNext = BURST;
                end
            end
            BURST: begin
                BusValid = 1'b1;
                if (BusReady && lastBeat) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign BusAdr  = BusValid ? entries[rdPtr].adr : '0;
    assign BusData = BusValid ? entries[rdPtr].line[int'(beatCnt)*BEATW +: BEATW] : '0;
    assign BusLast = BusValid & lastBeat;

    always_comb begin
        ProbeHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && (entries[i].adr == ProbeAdr)) begin
                ProbeHit = 1'b1;
            end
        end
    end

`ifdef CACHE_VICTIM_WBUF_FORWARD_EN
    logic [PTRW-1:0] fwdIdx;

    // Walk oldest to youngest so the youngest duplicate wins.
    always_comb begin
        ProbeData = '0;
        fwdIdx    = rdPtr;
        for (int k = 0; k < DEPTH; k++) begin
            fwdIdx = rdPtr + PTRW'(k);
            if (entries[fwdIdx].valid && (entries[fwdIdx].adr == ProbeAdr)) begin
                ProbeData = entries[fwdIdx].line;
            end
        end
    end
`else
    assign ProbeData = '0;
`endif

    // The replacement policy must name exactly one way whenever an eviction is requested.
    assert property (@(posedge clk) disable iff (!reset_n) EvictReq |-> $onehot(VictimWay));

endmodule

// File: tb/tb_cache_victim_wbuf.sv
// Randomized self-checking bench for cache_victim_wbuf against a queue-based reference model.
// Honours CACHE_VICTIM_WBUF_FORWARD_EN when predicting ProbeData.
module tb_cache_victim_wbuf;
    import cache_pkg::*;

    localparam int NUMWAYS = CACHE_NUMWAYS;
    localparam int LINELEN = CACHE_LINELEN;
    localparam int BEATW   = CACHE_BEATW;
    localparam int ADRW    = CACHE_ADRW;
    localparam int DEPTH   = CACHE_DEPTH;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic                       EvictReq;
    logic                       EvictReady;
    logic [NUMWAYS-1:0]         VictimWay;
    logic [NUMWAYS-1:0]         DirtyWay;
    logic [NUMWAYS*LINELEN-1:0] LineDataWay;
    logic [ADRW-1:0]            VictimAdr;
    logic                       BusValid;
    logic [ADRW-1:0]            BusAdr;
    logic [BEATW-1:0]           BusData;
    logic                       BusLast;
    logic                       BusReady;
    logic [ADRW-1:0]            ProbeAdr;
    logic                       ProbeHit;
    logic [LINELEN-1:0]         ProbeData;
    logic                       Empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADRW-1:0]    adr;
        logic [LINELEN-1:0] line;
    } ent_t;

    // Reference model: pending victims in FIFO order plus the current burst position.
    ent_t q[$];
    bit   burst   = 0;
    int   beatIdx = 0;

    cache_victim_wbuf dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .EvictReq   (EvictReq),
        .EvictReady (EvictReady),
        .VictimWay  (VictimWay),
        .DirtyWay   (DirtyWay),
        .LineDataWay(LineDataWay),
        .VictimAdr  (VictimAdr),
        .BusValid   (BusValid),
        .BusAdr     (BusAdr),
        .BusData    (BusData),
        .BusLast    (BusLast),
        .BusReady   (BusReady),
        .ProbeAdr   (ProbeAdr),
        .ProbeHit   (ProbeHit),
        .ProbeData  (ProbeData),
        .Empty      (Empty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [LINELEN-1:0] observed,
                               input logic [LINELEN-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic randomLines();
        for (int i = 0; i < NUMWAYS * LINELEN / 32; i++) begin
            LineDataWay[i*32 +: 32] = $urandom;
        end
    endtask

    // Compare every output against what the model says this cycle should look like.
    task automatic checkNow();
        logic [LINELEN-1:0] head;
        logic [LINELEN-1:0] fwd;
        logic [BEATW-1:0]   expData;
        logic [ADRW-1:0]    expAdr;
        logic               expLast;
        logic               hit;
        hit     = 1'b0;
        fwd     = '0;
        expData = '0;
        expAdr  = '0;
        expLast = 1'b0;
        foreach (q[i]) begin
            if (q[i].adr == ProbeAdr) begin
                hit = 1'b1;
                fwd = q[i].line;
            end
        end
        if (burst) begin
            head    = q[0].line;
            expData = BEATW'(head >> (beatIdx * BEATW));
            expAdr  = q[0].adr;
            expLast = (beatIdx == BEATS - 1);
        end
        checkOutput("EvictReady", LINELEN'(EvictReady), LINELEN'(q.size() < DEPTH));
        checkOutput("Empty", LINELEN'(Empty), LINELEN'(q.size() == 0));
        checkOutput("BusValid", LINELEN'(BusValid), LINELEN'(burst));
        checkOutput("BusAdr", LINELEN'(BusAdr), LINELEN'(expAdr));
        checkOutput("BusData", LINELEN'(BusData), LINELEN'(expData));
        checkOutput("BusLast", LINELEN'(BusLast), LINELEN'(expLast));
        checkOutput("ProbeHit", LINELEN'(ProbeHit), LINELEN'(hit));
`ifdef CACHE_VICTIM_WBUF_FORWARD_EN
        checkOutput("ProbeData", ProbeData, fwd);
`else
        checkOutput("ProbeData", ProbeData, '0);
`endif
    endtask

    // One clock: check at the falling edge, then advance the model across the rising edge.
    task automatic runCycle();
        bit                 accept;
        bit                 lastAcc;
        bit                 cap;
        int                 way;
        logic [LINELEN-1:0] capLine;
        @(negedge clk);
        checkNow();
        accept  = burst && BusReady;
        lastAcc = accept && (beatIdx == BEATS - 1);
        cap     = EvictReq && (q.size() < DEPTH) && ((VictimWay & DirtyWay) != '0);
        way     = 0;
        for (int i = 0; i < NUMWAYS; i++) begin
            if (VictimWay[i]) way = i;
        end
        capLine = LINELEN'(LineDataWay >> (way * LINELEN));
        @(posedge clk);
        if (burst) begin
            if (lastAcc) burst = 0;
            else if (accept) beatIdx++;
        end else if (q.size() > 0) begin
            burst   = 1;
            beatIdx = 0;
        end
        if (lastAcc) void'(q.pop_front());
        if (cap) q.push_back('{adr: VictimAdr, line: capLine});
        #1;
    endtask

    // Present an eviction and hold it until the model says the buffer has room.
    task automatic evictLine(input int way, input bit dirty, input logic [ADRW-1:0] adr);
        bit taken;
        randomLines();
        VictimWay      = '0;
        VictimWay[way] = 1'b1;
        DirtyWay       = NUMWAYS'($urandom);
        DirtyWay[way]  = dirty;
        VictimAdr      = adr;
        EvictReq       = 1'b1;
        taken          = 0;
        for (int n = 0; n < 40 && !taken; n++) begin
            taken = (q.size() < DEPTH);
            runCycle();
        end
        checkOutput("evictTaken", LINELEN'(taken), LINELEN'(1));
        EvictReq = 1'b0;
    endtask

    task automatic applyStimulus();
        EvictReq  = ($urandom_range(0, 99) < 35);
        VictimWay = '0;
        VictimWay[$urandom_range(0, NUMWAYS - 1)] = 1'b1;
        DirtyWay  = NUMWAYS'($urandom);
        VictimAdr = ADRW'($urandom_range(1, 6)) << 12;
        ProbeAdr  = ADRW'($urandom_range(1, 6)) << 12;
        BusReady  = ($urandom_range(0, 99) < 70);
        randomLines();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) runCycle();
    endtask

    initial begin
        bit reached;
        reset_n     = 1'b0;
        EvictReq    = 1'b0;
        VictimWay   = 4'b0001;
        DirtyWay    = '0;
        LineDataWay = '0;
        VictimAdr   = '0;
        BusReady    = 1'b0;
        ProbeAdr    = '0;

        #12;
        checkNow();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] dirty capture");
        BusReady = 1'b1;
        ProbeAdr = 56'h1000;
        evictLine(2, 1'b1, 56'h1000);
        idleCycles(12);

        $display("[TB] clean drop");
        evictLine(1, 1'b0, 56'h1400);
        idleCycles(4);

        $display("[TB] full backpressure");
        BusReady = 1'b0;
        evictLine(0, 1'b1, 56'h5000);
        evictLine(3, 1'b1, 56'h6000);
        idleCycles(3);
        BusReady = 1'b1;
        evictLine(1, 1'b1, 56'h7000);
        idleCycles(24);

        $display("[TB] stall stability");
        evictLine(2, 1'b1, 56'h3000);
        for (int i = 0; i < 24; i++) begin
            BusReady = (i % 4 == 0) || (i % 4 == 3);
            runCycle();
        end
        BusReady = 1'b1;
        idleCycles(6);

        $display("[TB] probe");
        ProbeAdr = 56'h2000;
        BusReady = 1'b0;
        evictLine(3, 1'b1, 56'h2000);
        idleCycles(4);
        BusReady = 1'b1;
        idleCycles(12);

        $display("[TB] reset mid-burst");
        evictLine(0, 1'b1, 56'h4000);
        reached = 0;
        for (int n = 0; n < 30 && !reached; n++) begin
            if (burst && beatIdx == 3) reached = 1;
            else runCycle();
        end
        checkOutput("reachBeat3", LINELEN'(reached), LINELEN'(1));
        #2;
        reset_n = 1'b0;
        #1;
        q.delete();
        burst   = 0;
        beatIdx = 0;
        checkNow();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idleCycles(12);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus();
            runCycle();
        end
        EvictReq = 1'b0;
        BusReady = 1'b1;
        idleCycles(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_victim_wbuf.md
Name: cache_victim_wbuf

Overview:
- Write-back victim buffer directly downstream of the cache replacement/victim-select stage.
- When the cache evicts a line, the block takes the one-hot victim way from the replacement policy and the per-way line data, dirty bits and tag address.
- Dirty victims are captured into a small FIFO and drained to the bus as a beat-wise burst; clean victims are dropped.
- The cache FSM can issue the refill immediately instead of waiting for the write-back.

Parameters:
- NUMWAYS, 4, ways per set; width of the one-hot victim vector.
- LINELEN, 512, cache line width in bits.
- BEATW, 64, bus data width in bits; LINELEN must be a multiple of BEATW.
- ADRW, 56, physical line address width in bits; the line offset is already zero.
- DEPTH, 2, number of victim entries; power of two and at least 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- EvictReq  in  1  evict the line selected by VictimWay this cycle
- EvictReady  out  1  buffer can accept an eviction
- VictimWay  in  NUMWAYS  one-hot victim way from the replacement policy
- DirtyWay  in  NUMWAYS  per-way dirty bits of the set
- LineDataWay  in  NUMWAYS*LINELEN  per-way line data; way i occupies bits [i*LINELEN +: LINELEN]
- VictimAdr  in  ADRW  line address of the victim
- BusValid  out  1  beat valid
- BusAdr  out  ADRW  line address of the current burst
- BusData  out  BEATW  current beat
- BusLast  out  1  final beat of the burst
- BusReady  in  1  bus accepts the beat
- ProbeAdr  in  ADRW  refill address checked for a pending victim
- ProbeHit  out  1  ProbeAdr matches an occupied entry
- ProbeData  out  LINELEN  line data of the matching entry (feature macro only)
- Empty  out  1  no pending victims; required before a cache flush completes

Behaviour:
- Reset: all entries invalid; write pointer, read pointer and beat counter = 0; drain FSM = IDLE.
- Reset outputs: EvictReady=1, BusValid=0, BusLast=0, ProbeHit=0, Empty=1. BusAdr, BusData and ProbeData are 0.
- Reset asserted mid-burst aborts the burst; no further beat is issued.
- Capture condition: EvictReq && EvictReady.
- On capture, the victim is the line selected by VictimWay (AND-OR mux). Its dirty bit is the matching DirtyWay bit.
  - Dirty victim: enqueue line and VictimAdr at the write pointer; write pointer increments and wraps mod DEPTH.
  - Clean victim: no state change.
- EvictReady = not full.
- EvictReq while full: ignored. The cache FSM must hold the request.
- VictimWay all-zero or not one-hot with EvictReq=1 is illegal: simulation assertion, no defined behaviour.
- Drain FSM, IDLE to BURST:
  - IDLE → BURST when the buffer is non-empty; the beat counter is cleared.
  - BURST: BusValid=1; BusAdr = head entry address; BusData = head line bits [cnt*BEATW +: BEATW], beat 0 = least significant.
  - BusLast=1 when cnt = LINELEN/BEATW-1.
- Drain FSM, beat handshake:
  - Beat accepted when BusValid && BusReady; cnt increments.
  - On an accepted last beat: the head entry is invalidated, the read pointer advances, and the FSM returns to IDLE.
  - Next burst starts no earlier than the following cycle, so there is one idle cycle between bursts.
  - BusValid, BusAdr and BusData stay stable while BusReady=0.
- Simultaneous capture and last-beat drain while full:
  - EvictReady reflects registered occupancy, so it stays 0 that cycle.
  - No bypass from drain to capture.
- Simultaneous capture into an empty buffer: the entry is visible to the FSM next cycle; first BusValid arrives 2 cycles after capture.
- ProbeHit is combinational: OR over occupied entries of (addr == ProbeAdr).
  - The entry currently bursting counts until its last beat is accepted.
  - The cache FSM must stall a refill on ProbeHit, unless the feature macro is defined.
- Empty = no occupied entries, registered.
- Duplicate addresses: a second capture of the same address while the first is pending is legal. Entries drain in FIFO order.

Optional Feature:
- Macro: CACHE_VICTIM_WBUF_FORWARD_EN.
- Defined:
  - ProbeData returns the line of the matching entry; youngest wins on duplicates.
  - The refill may be served from the buffer; the entry still drains to the bus.
- Undefined:
  - ProbeData is tied to 0 and no data mux is built.
  - ProbeHit only stalls the refill.

Decomposition:
- Shared package cache_pkg:
  - drain state enum {IDLE, BURST};
  - constant BEATS = LINELEN/BEATW;
  - victim entry struct {valid, adr, line}.
- One sub-module, cache_victim_sel: one-hot AND-OR mux that selects the line and dirty bit from VictimWay. It is reusable by the cache data path.

Test Plan:
- Dirty capture: LINELEN=512, BEATW=64, DirtyWay=4'b0100, VictimWay=4'b0100, VictimAdr=0x1000, BusReady=1 → BusValid high 2 cycles later; 8 beats with way-2 data, beat0 = bits[63:0]; BusLast on beat 7; then Empty=1.
- Clean drop: VictimWay=4'b0010, DirtyWay=4'b0000 → no bus activity; Empty stays 1; EvictReady stays 1.
- Full backpressure: 3 dirty evictions with BusReady=0 → EvictReady=0 after the 2nd; 3rd is held. After 8 accepted beats, the 3rd is captured and drains after the 2nd.
- Stall stability: BusReady toggles 1,0,0,1 → BusData/BusAdr hold during the stalls; beat order is unchanged.
- Probe: pending victim 0x2000, ProbeAdr=0x2000 → ProbeHit=1 until the last beat is accepted, 0 after. With CACHE_VICTIM_WBUF_FORWARD_EN, ProbeData = the captured line.
- Reset: reset_n low at beat 3 → BusValid=0 immediately (asynchronous); Empty=1, EvictReady=1; no beats after release.
